// File: rtl/pc_unit_pkg.sv
// Shared encodings for the PC unit: branch kinds, widths and FSM states.
package pc_unit_pkg;

  localparam int unsigned BRANCH_WIDTH = 4;

  typedef enum logic [BRANCH_WIDTH-1:0] {
    BRANCH_DISABLE = 4'd0,
    BRANCH_EQ      = 4'd1,
    BRANCH_NE      = 4'd2,
    BRANCH_JAL     = 4'd3,
    BRANCH_JALR    = 4'd4,
    BRANCH_LT      = 4'd5,
    BRANCH_GE      = 4'd6,
    BRANCH_LTU     = 4'd7,
    BRANCH_GEU     = 4'd8
  } branch_t;

  typedef enum logic {
    ST_FETCH = 1'b0,
    ST_HALT  = 1'b1
  } state_t;

endpackage

// File: rtl/pc_unit_if.sv
// Instruction-fetch request handshake between the PC unit and instruction memory.
interface pc_unit_if #(
  parameter int unsigned XLEN = 32
);
  logic            fetch_valid;
  logic            fetch_ready;
  logic [XLEN-1:0] fetch_pc;

  modport master (output fetch_valid, output fetch_pc, input fetch_ready);
  modport slave  (input fetch_valid, input fetch_pc, output fetch_ready);
endinterface

// File: rtl/pc_unit_branch_resolve.sv
// Combinational branch resolution: taken decision, target address and alignment check.
module branch_resolve
  import pc_unit_pkg::*;
#(
  parameter int unsigned XLEN = 32,
  parameter int unsigned RVC  = 0
) (
  input  logic [BRANCH_WIDTH-1:0] res_type,
  input  logic                    res_zero,
  input  logic                    res_lt,
  input  logic                    res_ltu,
  input  logic [XLEN-1:0]         res_pc,
  input  logic [XLEN-1:0]         res_offset,
  input  logic [XLEN-1:0]         res_base,
  output logic                    taken,
  output logic [XLEN-1:0]         target,
  output logic                    misaligned
);

  logic [XLEN-1:0] pc_sum;
  logic [XLEN-1:0] base_sum;

  assign pc_sum   = res_pc + res_offset;
  assign base_sum = res_base + res_offset;

  always_comb begin
    taken  = 1'b0;
    target = pc_sum;
    case (res_type)
      BRANCH_EQ:   taken = res_zero;
      BRANCH_NE:   taken = !res_zero;
      BRANCH_LT:   taken = res_lt;
      BRANCH_GE:   taken = !res_lt;
      BRANCH_LTU:  taken = res_ltu;
      BRANCH_GEU:  taken = !res_ltu;
      BRANCH_JAL:  taken = 1'b1;
      BRANCH_JALR: begin
        taken  = 1'b1;
        target = {base_sum[XLEN-1:1], 1'b0};
      end
      default:     taken = 1'b0;
    endcase
  end

  // With compressed instructions only halfword alignment is required.
  assign misaligned = (RVC != 0) ? target[0] : (target[1:0] != 2'b00);

endmodule

// File: rtl/pc_unit.sv
// Program counter unit: fetch request generation, redirects on branches/traps, halt on misaligned target.
module pc_unit
  import pc_unit_pkg::*;
#(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int unsigned     RVC      = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    stall,
  input  logic                    res_valid,
  input  logic [BRANCH_WIDTH-1:0] res_type,
  input  logic                    res_zero,
  input  logic                    res_lt,
  input  logic                    res_ltu,
  input  logic [XLEN-1:0]         res_pc,
  input  logic [XLEN-1:0]         res_offset,
  input  logic [XLEN-1:0]         res_base,
  input  logic                    trap,
  input  logic [XLEN-1:0]         trap_vec,
  pc_unit_if.master               fetch,
  output logic [XLEN-1:0]         link_addr,
  output logic                    redirect,
  output logic                    misalign,
  output logic [XLEN-1:0]         misalign_addr,
  output logic [XLEN-1:0]         fetch_count
);

  state_t          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] count_q, count_d;
  logic [XLEN-1:0] maddr_q, maddr_d;
  logic            redirect_q, redirect_d;
  logic            misalign_q, misalign_d;

  logic            br_taken;
  logic            br_misaligned;
  logic [XLEN-1:0] br_target;

  branch_resolve #(.XLEN(XLEN), .RVC(RVC)) u_resolve (
    .res_type   (res_type),
    .res_zero   (res_zero),
    .res_lt     (res_lt),
    .res_ltu    (res_ltu),
    .res_pc     (res_pc),
    .res_offset (res_offset),
    .res_base   (res_base),
    .taken      (br_taken),
    .target     (br_target),
    .misaligned (br_misaligned)
  );

  assign fetch.fetch_valid = (state_q == ST_FETCH) && !stall;
  assign fetch.fetch_pc    = pc_q;
  assign link_addr         = res_pc + XLEN'(4);
  assign redirect          = redirect_q;
  assign misalign          = misalign_q;
  assign misalign_addr     = maddr_q;
  assign fetch_count       = count_q;

  // Priority: trap, then a taken resolution (only in FETCH), then the fetch handshake.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    count_d    = count_q;
    maddr_d    = maddr_q;
    redirect_d = 1'b0;
    misalign_d = 1'b0;
    if (trap) begin
      pc_d       = trap_vec;
      state_d    = ST_FETCH;
      redirect_d = 1'b1;
    end else if (res_valid && br_taken && (state_q == ST_FETCH)) begin
      if (br_misaligned) begin
        state_d    = ST_HALT;
        misalign_d = 1'b1;
        maddr_d    = br_target;
      end else begin
        pc_d       = br_target;
        redirect_d = 1'b1;
      end
    end else if (fetch.fetch_valid && fetch.fetch_ready) begin
      pc_d    = pc_q + XLEN'(4);
      count_d = count_q + XLEN'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_FETCH;
      pc_q       <= RESET_PC;
      count_q    <= '0;
      maddr_q    <= '0;
      redirect_q <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      count_q    <= count_d;
      maddr_q    <= maddr_d;
      redirect_q <= redirect_d;
      misalign_q <= misalign_d;
    end
  end

endmodule

// File: doc/pc_unit.md
PC_UNIT -- requirements
Module: pc_unit

Interface
REQ-001 Parameter XLEN, default 32: width of all address and data ports.
REQ-002 Parameter RESET_PC, default 0: PC loaded on reset.
REQ-003 Parameter RVC, default 0: 0 requires 4-byte target alignment; 1 requires 2-byte alignment.
REQ-004 clk  in  1  sole clock, rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 stall  in  1  downstream cannot accept an instruction.
REQ-007 res_valid  in  1  execute stage presents a control-flow resolution this cycle.
REQ-008 res_type  in  BRANCH_WIDTH  branch kind: DISABLE, EQ, NE, LT, GE, LTU, GEU, JAL, JALR.
REQ-009 res_zero, res_lt, res_ltu  in  1 each  comparator flags for the resolving instruction.
REQ-010 res_pc  in  XLEN  PC of the resolving instruction.
REQ-011 res_offset  in  XLEN  sign-extended immediate.
REQ-012 res_base  in  XLEN  rs1 value for JALR.
REQ-013 trap  in  1  trap request; trap_vec  in  XLEN  trap target.
REQ-014 fetch_valid  out  1  fetch request valid.
REQ-015 fetch_ready  in  1  instruction memory accepts the request.
REQ-016 fetch_pc  out  XLEN  address of the current request.
REQ-017 link_addr  out  XLEN  res_pc+4, combinational.
REQ-018 redirect  out  1  one-cycle pulse when the PC is redirected by a taken resolution or a trap.
REQ-019 misalign  out  1  one-cycle pulse on a misaligned taken target; misalign_addr  out  XLEN  the offending target, held until the next pulse.
REQ-020 fetch_count  out  XLEN  count of accepted fetches.

Function
REQ-021 States: FETCH (fetch_valid = !stall) and HALT (fetch_valid=0).
REQ-022 Taken is defined per res_type: EQ taken=res_zero; NE taken=!res_zero; LT taken=res_lt; GE taken=!res_lt; LTU taken=res_ltu; GEU taken=!res_ltu; JAL and JALR always taken; DISABLE and undefined encodings never taken.
REQ-023 Target is res_pc+res_offset for conditional branches and JAL; it is (res_base+res_offset) with bit 0 cleared for JALR; the sum is modulo 2^XLEN.
REQ-024 A target is misaligned when target[1:0]!=0 with RVC=0, or when target[0]!=0 with RVC=1 (this never occurs for JALR).
REQ-025 Per-cycle priority: rst > trap > taken res_valid > stall > handshake.
REQ-026 On trap (either state): next fetch_pc=trap_vec, state->FETCH, redirect=1 next cycle; any simultaneous resolution is ignored.
REQ-027 On a taken, aligned resolution in FETCH: next fetch_pc=target, redirect=1 next cycle, and any un-accepted request is abandoned.
REQ-028 On a taken, misaligned resolution in FETCH: fetch_pc unchanged, state->HALT, misalign=1 next cycle, misalign_addr=target.
REQ-029 res_valid in HALT is ignored.
REQ-030 With no redirect and fetch_valid&&fetch_ready: fetch_pc advances by 4 and fetch_count increments.
REQ-031 With fetch_valid&&!fetch_ready: fetch_pc is held stable.
REQ-032 With stall: fetch_pc and fetch_count are held.
REQ-033 fetch_pc may change while fetch_valid=1 only on a redirect or a trap.
REQ-034 fetch_pc+4 and fetch_count wrap modulo 2^XLEN without any flag.
REQ-035 Latency: a redirect is visible on fetch_pc one cycle after the resolution is presented.

Reset
REQ-036 When rst=1 at a clock edge: fetch_pc=RESET_PC, state=FETCH, fetch_count=0, redirect=0, misalign=0, misalign_addr=0.
REQ-037 rst overrides all other inputs in the same cycle, including a trap or resolution presented mid-operation.
REQ-038 fetch_valid=1 in the first cycle after reset when stall=0.

Structure
REQ-039 A shared package holds BRANCH_WIDTH=4 and the encodings BRANCH_DISABLE=0, EQ=1, NE=2, JAL=3, JALR=4, LT=5, GE=6, LTU=7, GEU=8, plus the state encodings.
REQ-040 The combinational taken/target/alignment logic is one sub-module, branch_resolve; pc_unit holds the registers and the FSM.

Verification
REQ-041 Reset with RESET_PC=0x100, fetch_ready=1 for 3 cycles -> fetch_pc 0x100, 0x104, 0x108; fetch_count=3.
REQ-042 fetch_ready=0 for 2 cycles at 0x104 -> fetch_pc held at 0x104 and fetch_count unchanged; on fetch_ready=1 -> 0x108.
REQ-043 res_type=NE, res_zero=0, res_pc=0x200, res_offset=0xFFFFFFF8 -> fetch_pc=0x1F8 next cycle with a redirect pulse; with res_zero=1 -> no redirect.
REQ-044 JALR with res_base=0x301, res_offset=0x4 -> fetch_pc=0x304; link_addr=res_pc+4.
REQ-045 RVC=0, JAL with res_pc=0x10, offset=0x2 -> misalign pulse, misalign_addr=0x12, fetch_valid=0; then trap with trap_vec=0x80 -> fetch_pc=0x80, fetch_valid=1.
REQ-046 trap and a taken resolution in the same cycle -> fetch_pc=trap_vec; fetch_pc=0xFFFFFFFC accepted -> fetch_pc wraps to 0x0.
